// File: rtl/rate_tick_pkg.sv
// rtl/rate_tick_pkg.sv - shared types and helpers for the rate tick scheduler
package rate_tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALIGN = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 16;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_tick_nco.sv
// rtl/rate_tick_nco.sv - one phase-accumulator channel producing a carry strobe and square wave
module rate_tick_nco
  import rate_tick_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [ACC_W-1:0] inc,
  output logic             tick,
  output logic             ph
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
      ph   <= 1'b0;
    end else if (clr) begin
      acc  <= '0;
      tick <= 1'b0;
      ph   <= 1'b0;
    end else if (step) begin
      acc  <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
      if (sum[ACC_W]) ph <= ~ph;
    end else begin
      // Holding edges (e.g. leaving ALIGN) keep the phase but never strobe.
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/rate_tick_scheduler.sv
// rtl/rate_tick_scheduler.sv - aligned multi-rate tick and phase generator from one base clock
module rate_tick_scheduler
  import rate_tick_pkg::*;
#(
  parameter int               NUM_CH  = 2,
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RST = '0,
  localparam int              CH_W    = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              align_req,
  output logic              align_done,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] ph,
  output logic [1:0]        state_o
);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] inc_q [NUM_CH];
  logic             cfg_acc;
  logic             cfg_bad;
  logic             step;
  logic             clr;

  assign cfg_ready = (state != ALIGN);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_bad   = ({1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH));
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        if (!en)            state_nxt = IDLE;
        else if (align_req) state_nxt = ALIGN;
      end
      ALIGN:   state_nxt = en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The edge that enters RUN never accumulates, so every channel starts from a common origin.
  assign step = (state == RUN) && en && !align_req;
  assign clr  = (state_nxt != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      align_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      align_done <= (state == ALIGN) && en;
      cfg_err    <= cfg_acc && cfg_bad;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // The NCO sees the registered increment, so a write on a carrying edge still carries with the old value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inc_q[i] <= INC_RST;
      end else if (cfg_acc && !cfg_bad && (cfg_ch == CH_W'(i))) begin
        inc_q[i] <= cfg_inc;
      end
    end

    rate_tick_nco #(
      .ACC_W(ACC_W)
    ) u_nco (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .step (step),
      .inc  (inc_q[i]),
      .tick (tick[i]),
      .ph   (ph[i])
    );
  end

endmodule

// File: tb/tb_rate_tick_scheduler.sv
// tb/tb_rate_tick_scheduler.sv - self-checking bench for rate_tick_scheduler
module tb_rate_tick_scheduler;

  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           align_req = 1'b0;
  logic           align_done;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [15:0]    cfg_inc = '0;
  logic           cfg_err;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] ph;
  logic [1:0]     state_o;

  rate_tick_scheduler #(
    .NUM_CH (NCH),
    .ACC_W  (16),
    .INC_RST(16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .align_req (align_req),
    .align_done(align_done),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .ph        (ph),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] ph;
    logic [1:0]     st;
    logic           done;
    logic           err;
  } exp_t;

  typedef struct {
    logic [15:0] inc0;
    logic [15:0] inc1;
    int          n;
    int          cnt0;
    int          cnt1;
    int          first0;
    int          first1;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int m_state;
  int m_acc[NCH];
  int m_inc[NCH];
  bit m_tick[NCH];
  bit m_ph[NCH];
  bit m_done;
  bit m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_done  = 0;
    m_err   = 0;
    for (int c = 0; c < NCH; c++) begin
      m_acc[c]  = 0;
      m_inc[c]  = 0;
      m_tick[c] = 0;
      m_ph[c]   = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    int nxt;
    int s;
    bit take;
    bit stp;
    take = cfg_valid && (m_state != 2);
    stp  = (m_state == 1) && en && !align_req;
    case (m_state)
      0:       nxt = en ? 1 : 0;
      1:       nxt = !en ? 0 : (align_req ? 2 : 1);
      default: nxt = en ? 1 : 0;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (stp) begin
        s         = m_acc[c] + m_inc[c];
        m_tick[c] = (s >= 65536);
        m_acc[c]  = s % 65536;
        if (m_tick[c]) m_ph[c] = !m_ph[c];
      end else if (nxt == 0 || nxt == 2) begin
        m_acc[c]  = 0;
        m_tick[c] = 0;
        m_ph[c]   = 0;
      end else begin
        m_tick[c] = 0;
      end
    end
    m_done = (m_state == 2) && en;
    m_err  = take && (int'(cfg_ch) >= NCH);
    if (take && int'(cfg_ch) < NCH) m_inc[cfg_ch] = int'(cfg_inc);
    m_state = nxt;
    for (int c = 0; c < NCH; c++) begin
      e.tick[c] = m_tick[c];
      e.ph[c]   = m_ph[c];
    end
    e.st   = 2'(m_state);
    e.done = m_done;
    e.err  = m_err;
  endtask

  // One clock: check the combinational ready, predict, clock, then compare the prediction.
  task automatic cycle();
    exp_t e;
    chk("cfg_ready", int'(cfg_ready), (m_state != 2) ? 1 : 0);
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_tick", int'(tick), int'(e.tick));
    chk("sb_ph", int'(ph), int'(e.ph));
    chk("sb_state", int'(state_o), int'(e.st));
    chk("sb_align_done", int'(align_done), int'(e.done));
    chk("sb_cfg_err", int'(cfg_err), int'(e.err));
  endtask

  task automatic run_count(input int n, output int c0, output int c1, output int f0, output int f1);
    c0 = 0; c1 = 0; f0 = 0; f1 = 0;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (tick[0]) begin c0++; if (f0 == 0) f0 = i; end
      if (tick[1]) begin c1++; if (f1 == 0) f1 = i; end
    end
  endtask

  task automatic write_inc(input logic [1:0] ch, input logic [15:0] v);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = v;
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int c0, c1, f0, f1;

    vecs[0] = '{16'h4000, 16'h2000, 32, 8, 4, 4, 8};
    vecs[1] = '{16'h2800, 16'h0000, 64, 10, 0, 7, 0};
    vecs[2] = '{16'h8000, 16'hFFFF, 16, 8, 15, 2, 2};
    vecs[3] = '{16'h0000, 16'h0001, 20, 0, 0, 0, 0};

    model_reset();
    #12;
    chk("rst_state", int'(state_o), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ph", int'(ph), 0);
    chk("rst_align_done", int'(align_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      en = 1'b0;
      cycle();
      write_inc(2'd0, vecs[v].inc0);
      write_inc(2'd1, vecs[v].inc1);
      en = 1'b1;
      cycle();
      run_count(vecs[v].n, c0, c1, f0, f1);
      chk($sformatf("vec%0d_cnt0", v), c0, vecs[v].cnt0);
      chk($sformatf("vec%0d_cnt1", v), c1, vecs[v].cnt1);
      chk($sformatf("vec%0d_first0", v), f0, vecs[v].first0);
      chk($sformatf("vec%0d_first1", v), f1, vecs[v].first1);
    end

    // Plain align in mid-run: both channels restart from a shared origin.
    write_inc(2'd0, 16'h4000);
    write_inc(2'd1, 16'h2000);
    run_count(5, c0, c1, f0, f1);
    align_req = 1'b1;
    cycle();
    align_req = 1'b0;
    chk("align_state", int'(state_o), 2);
    chk("align_ph_clr", int'(ph), 0);
    cycle();
    chk("align_done_pulse", int'(align_done), 1);
    run_count(8, c0, c1, f0, f1);
    chk("align_first0", f0, 4);
    chk("align_first1", f1, 8);
    chk("align_done_once", int'(align_done), 0);

    // Write coincident with align, then a write held off while in ALIGN.
    align_req = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_inc   = 16'h8000;
    cycle();
    align_req = 1'b0;
    cfg_ch    = 2'd0;
    cfg_inc   = 16'h4000;
    chk("align_cfg_ready_low", int'(cfg_ready), 0);
    cycle();
    cycle();
    cfg_valid = 1'b0;
    chk("post_align_tick1_edge1", int'(tick[1]), 0);
    run_count(8, c0, c1, f0, f1);
    chk("fast_cnt1", c1, 4);
    chk("fast_first1", f1, 1);

    // Out-of-range channel: flagged, nothing changes.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_inc   = 16'hFFFF;
    cycle();
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    cycle();
    chk("cfg_err_clear", int'(cfg_err), 0);
    run_count(8, c0, c1, f0, f1);
    chk("after_err_cnt0", c0, 2);
    chk("after_err_cnt1", c1, 4);

    // Disable and re-enable: increments kept, first-tick latency reproduced.
    en = 1'b0;
    cycle();
    chk("disable_state", int'(state_o), 0);
    en = 1'b1;
    cycle();
    run_count(8, c0, c1, f0, f1);
    chk("reenable_first0", f0, 4);
    chk("reenable_first1", f1, 2);

    // Asynchronous reset mid-run.
    run_count(3, c0, c1, f0, f1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", int'(tick), 0);
    chk("arst_ph", int'(ph), 0);
    chk("arst_align_done", int'(align_done), 0);
    chk("arst_cfg_err", int'(cfg_err), 0);
    chk("arst_state", int'(state_o), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle();
    run_count(16, c0, c1, f0, f1);
    chk("arst_inc_cnt0", c0, 0);
    chk("arst_inc_cnt1", c1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
